// File: rtl/axil_pkg.sv
// Shared AXI4-lite definitions: response codes and the read-bridge state encoding.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } rd_state_e;

endpackage

// File: rtl/axil_reg_bridge_rd.sv
// AXI4-lite read slave driving a single-outstanding register read port.
// Optional access timeout (SLVERR) enabled by macro AXIL_REG_BRIDGE_RD_TIMEOUT_EN.
module axil_reg_bridge_rd
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_wait,
  input  logic                  reg_rd_ack
);

  // STRB_WIDTH is a power of two; clearing its low bits word-aligns the address.
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_WIDTH'(STRB_WIDTH - 1));

  rd_state_e             state_q, state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  en_q, en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  ar_hs_s;
  logic                  timeout_s;
  logic                  unused_s;

  assign ar_hs_s  = (state_q == IDLE) && s_axil_arvalid && arready_q;
  assign unused_s = ^{s_axil_arprot, (TIMEOUT > 0)};

`ifdef AXIL_REG_BRIDGE_RD_TIMEOUT_EN
  localparam int              CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(TIMEOUT);
  localparam bit              TO_ACTIVE = (TIMEOUT > 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A zero TIMEOUT keeps timeout_s low so the bridge waits for ack forever.
  assign timeout_s = TO_ACTIVE && (state_q == REQ) && (cnt_q == {CNT_W{1'b0}});

  // Timeout counter next state: load on AR accept, count idle REQ cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (ar_hs_s) begin
      cnt_d = CNT_LOAD;
    end else if ((state_q == REQ) && !reg_rd_ack && !reg_rd_wait &&
                 (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and output logic of the IDLE/REQ/RESP sequencer.
  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    en_d      = en_q;
    addr_d    = addr_q;

    case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (ar_hs_s) begin
          addr_d    = s_axil_araddr & ADDR_MASK;
          en_d      = 1'b1;
          arready_d = 1'b0;
          state_d   = REQ;
        end else begin
          state_d = IDLE;
        end
      end

      REQ: begin
        // Ack is checked first so a same-cycle ack beats the timeout.
        if (reg_rd_ack) begin
          rdata_d  = reg_rd_data;
          rresp_d  = RESP_OKAY;
          en_d     = 1'b0;
          rvalid_d = 1'b1;
          state_d  = RESP;
        end else if (timeout_s) begin
          rdata_d  = {DATA_WIDTH{1'b0}};
          rresp_d  = RESP_SLVERR;
          en_d     = 1'b0;
          rvalid_d = 1'b1;
          state_d  = RESP;
        end else begin
          state_d = REQ;
        end
      end

      RESP: begin
        if (rvalid_q && s_axil_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = RESP;
        end
      end

      default: begin
        state_d   = IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        en_d      = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= {DATA_WIDTH{1'b0}};
      rresp_q   <= 2'b00;
      en_q      <= 1'b0;
      addr_q    <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      en_q      <= en_d;
      addr_q    <= addr_d;
    end
  end

  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign reg_rd_en      = en_q;
  assign reg_rd_addr    = addr_q;

endmodule
